sha256_pad_stream: RTL

Parametrised SHA-256 message padder and block sequencer for the PBKDF2/HMAC datapath. It generalises the fixed 1024-bit message input of the HMAC core to any maximum message size. It accepts one message of up to `MAX_BYTES_P` bytes plus a count of previously-hashed 64-byte prefix blocks, then emits the FIPS 180-4 padded message as a stream of 512-bit blocks over a valid/ready handshake. It sits between the message source (HMAC key/salt/U-value muxing) and the SHA-256 compression core.

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_pad_blk_gen.sv | 68 ++++++
 rtl/sha256_pad_stream.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants, FSM state type and block-count helper for the SHA-256
// message padder (sha256_pad_stream) and its block generator.
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int unsigned SHA256_BLK_BITS       = 512;
    localparam int unsigned SHA256_BLK_BYTES      = SHA256_BLK_BITS / 8;
    localparam int unsigned SHA256_LEN_FIELD_BITS = 64;
    localparam logic [7:0]  SHA256_PAD_BYTE       = 8'h80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } pad_state_e;

    // Number of 512-bit blocks needed for len message bytes plus the 0x80
    // marker and the 8-byte length field.
    function automatic int unsigned sha256_nblocks(input int unsigned len);
        return ((len + 32'd8) >> 6) + 32'd1;
    endfunction

endpackage

// File: rtl/sha256_pad_blk_gen.sv
// ---------------------------------------------------------------------------
// sha256_pad_blk_gen
// Combinational generator of one padded 512-bit block of a captured message.
//   msg_i  : message, byte 0 in the MSBs
//   len_i  : message length in bytes (may exceed MAX_BYTES_P; those bytes read 0)
//   pre_i  : count of 64-byte blocks hashed before this message
//   idx_i  : index of the block to produce
//   last_i : block idx_i is the final block (carries the length field)
//   blk_o  : padded block, byte 0 in the MSBs
// ---------------------------------------------------------------------------
module sha256_pad_blk_gen
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES_P = 128,
    parameter int unsigned LEN_W_P     = 8,
    parameter int unsigned PRE_W_P     = 2,
    parameter int unsigned IDX_W_P     = 2
) (
    input  logic [8*MAX_BYTES_P-1:0]   msg_i,
    input  logic [LEN_W_P-1:0]         len_i,
    input  logic [PRE_W_P-1:0]         pre_i,
    input  logic [IDX_W_P-1:0]         idx_i,
    input  logic                       last_i,
    output logic [SHA256_BLK_BITS-1:0] blk_o
);

    localparam int unsigned MI_W = (MAX_BYTES_P > 1) ? $clog2(MAX_BYTES_P) : 1;

    logic [MAX_BYTES_P-1:0][7:0]                 msg_b;
    logic [SHA256_BLK_BYTES-1:0][7:0]            blk_b;
    logic [SHA256_LEN_FIELD_BITS-1:0]            l_bits;
    logic [31:0]                                 len32;

    assign msg_b  = msg_i;
    assign blk_o  = blk_b;
    assign len32  = 32'(len_i);
    // L = 8 * (64*pre + len), in bits
    assign l_bits = (64'(pre_i) << 9) + (64'(len_i) << 3);

    for (genvar k = 0; k < SHA256_BLK_BYTES; k++) begin : g_byte
        logic [31:0] g;
        logic [7:0]  len_byte;
        logic [7:0]  b;

        assign g = 32'({idx_i, 6'(k)});

        // Only the last 8 byte lanes can ever carry the length field.
        if (k >= 56) begin : g_len
            assign len_byte = l_bits[8*(63-k) +: 8];
        end else begin : g_nolen
            assign len_byte = 8'h00;
        end

        always_comb begin
            b = 8'h00;
            if (g < len32) begin
                if (g < MAX_BYTES_P) b = msg_b[MI_W'(MAX_BYTES_P - 1 - g)];
            end else if (g == len32) begin
                b = SHA256_PAD_BYTE;
            end else if (last_i) begin
                b = len_byte;
            end
        end

        assign blk_b[SHA256_BLK_BYTES-1-k] = b;
    end

endmodule

// File: rtl/sha256_pad_stream.sv
// ---------------------------------------------------------------------------
// sha256_pad_stream
// SHA-256 message padder / block sequencer. Captures one message of up to
// MAX_BYTES_P bytes plus a prefix block count, then streams the padded
// message as 512-bit blocks over a valid/ready handshake.
//   clk_i, rst_ni          : clock, async active-low reset
//   in_valid_i/in_ready_o  : message handshake (ready only when idle)
//   msg_i, len_i, pre_i    : message (byte 0 in MSBs), byte length, prefix blocks
//   blk_valid_o/blk_ready_i: block handshake
//   blk_o                  : padded block (zero when idle)
//   blk_first_o/blk_last_o : block position flags
//   err_o                  : sticky over-length error
// Optional feature macro: SHA256_PAD_LEN_CHECK_EN -- clamp over-long lengths
// to MAX_BYTES_P and flag them on err_o; otherwise err_o is 0 and len_i is raw.
// ---------------------------------------------------------------------------
module sha256_pad_stream
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES_P = 128,
    parameter int unsigned LEN_W_P     = $clog2(MAX_BYTES_P + 1),
    parameter int unsigned PRE_W_P     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [8*MAX_BYTES_P-1:0]   msg_i,
    input  logic [LEN_W_P-1:0]         len_i,
    input  logic [PRE_W_P-1:0]         pre_i,
    output logic                       blk_valid_o,
    input  logic                       blk_ready_i,
    output logic [SHA256_BLK_BITS-1:0] blk_o,
    output logic                       blk_first_o,
    output logic                       blk_last_o,
    output logic                       err_o
);

    // Block index must cover the largest length that can reach the
    // generator; with the check disabled that is whatever len_i can encode.
    localparam int unsigned LEN_RAW_MAX = (1 << LEN_W_P) - 1;
    localparam int unsigned LEN_MAX     = (LEN_RAW_MAX > MAX_BYTES_P) ? LEN_RAW_MAX : MAX_BYTES_P;
    localparam int unsigned NBLK_MAX    = sha256_nblocks(LEN_MAX);
    localparam int unsigned IDX_W       = (NBLK_MAX > 1) ? $clog2(NBLK_MAX) : 1;

    pad_state_e                  state_q, state_d;
    logic [8*MAX_BYTES_P-1:0]    msg_q;
    logic [LEN_W_P-1:0]          len_q, len_cap;
    logic [PRE_W_P-1:0]          pre_q;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            last_idx_q, last_idx_cap;
    logic                        emit, accept, at_last;
    logic [SHA256_BLK_BITS-1:0]  blk_gen;

    assign emit    = (state_q == ST_EMIT);
    assign accept  = in_valid_i & ~emit;
    assign at_last = (idx_q == last_idx_q);

`ifdef SHA256_PAD_LEN_CHECK_EN
    logic len_over;
    logic err_q;

    assign len_over = (32'(len_i) > MAX_BYTES_P);
    assign len_cap  = len_over ? LEN_W_P'(MAX_BYTES_P) : len_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 err_q <= 1'b0;
        else if (accept && len_over) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign len_cap = len_i;
    assign err_o   = 1'b0;
`endif

    assign last_idx_cap = IDX_W'(sha256_nblocks(32'(len_cap)) - 32'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                if (blk_ready_i) begin
                    if (at_last) state_d = ST_IDLE;
                    else         idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            msg_q      <= '0;
            len_q      <= '0;
            pre_q      <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                msg_q      <= msg_i;
                len_q      <= len_cap;
                pre_q      <= pre_i;
                last_idx_q <= last_idx_cap;
            end
        end
    end

    sha256_pad_blk_gen #(
        .MAX_BYTES_P (MAX_BYTES_P),
        .LEN_W_P     (LEN_W_P),
        .PRE_W_P     (PRE_W_P),
        .IDX_W_P     (IDX_W)
    ) u_blk_gen (
        .msg_i  (msg_q),
        .len_i  (len_q),
        .pre_i  (pre_q),
        .idx_i  (idx_q),
        .last_i (at_last),
        .blk_o  (blk_gen)
    );

    // Idle block output is forced to zero so a stale capture never leaks.
    assign in_ready_o  = ~emit;
    assign blk_valid_o = emit;
    assign blk_o       = emit ? blk_gen : '0;
    assign blk_first_o = emit & (idx_q == '0);
    assign blk_last_o  = emit & at_last;

endmodule
